// File: rtl/fixfloat_conv_arbiter_if.sv
// fixfloat_conv_arbiter_if: request, converter and response signals around the shared
// fixed<->float converter; slave is the arbiter side, master the client/converter side.
interface fixfloat_conv_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_number;
    logic [NUM_REQ*5-1:0]  req_fixpos;
    logic [NUM_REQ-1:0]    req_opcode;
    logic [31:0]           conv_targetnumber;
    logic [4:0]            conv_fixpointpos;
    logic                  conv_opcode;
    logic [31:0]           conv_result;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_result;
    logic                  busy;
    modport slave (
        input  req_valid, req_number, req_fixpos, req_opcode, conv_result, rsp_ready,
        output req_ready, conv_targetnumber, conv_fixpointpos, conv_opcode,
        output rsp_valid, rsp_id, rsp_result, busy
    );
    modport master (
        output req_valid, req_number, req_fixpos, req_opcode, conv_result, rsp_ready,
        input  req_ready, conv_targetnumber, conv_fixpointpos, conv_opcode,
        input  rsp_valid, rsp_id, rsp_result, busy
    );
endinterface

// File: rtl/fixfloat_conv_arbiter.sv
// fixfloat_conv_arbiter: round-robin sharing of one fixed<->float converter between
// NUM_REQ requesters, returning each ID-tagged result over a valid/ready channel.
module fixfloat_conv_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int CONV_LAT = 1,
    parameter int ID_W     = 2
) (
    input logic clk,
    input logic rst,
    fixfloat_conv_arbiter_if.slave bus
);
    localparam int CW = $clog2(CONV_LAT + 1);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t          state, state_nx;
    logic [ID_W-1:0] rr_ptr, win, win_hi, win_lo;
    logic            hi, any;
    logic [CW-1:0]   cnt;
    logic [31:0]     sel_num;
    logic [4:0]      sel_fix;
    logic            sel_op;
    // Lowest valid index above rr_ptr wins; otherwise wrap to the lowest valid index overall.
    always_comb begin
        win_hi = '0;
        win_lo = '0;
        hi     = 1'b0;
        any    = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                win_lo = ID_W'(i);
                any    = 1'b1;
                if (ID_W'(i) > rr_ptr) begin
                    win_hi = ID_W'(i);
                    hi     = 1'b1;
                end
            end
        end
        win = hi ? win_hi : win_lo;
    end
    always_comb begin
        sel_num = '0;
        sel_fix = '0;
        sel_op  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == win) begin
                sel_num = bus.req_number[32*i +: 32];
                sel_fix = bus.req_fixpos[5*i +: 5];
                sel_op  = bus.req_opcode[i];
            end
        end
    end
    always_comb begin
        state_nx = (state == IDLE && any)           ? WAIT :
                   (state == WAIT && cnt == '0)     ? RESP :
                   (state == RESP && bus.rsp_ready) ? IDLE : state;
    end
    assign bus.req_ready = (state == IDLE && any) ? NUM_REQ'(1) << win : '0;
    assign bus.busy      = state != IDLE;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end
    // cnt counts down the converter latency; capture happens on the edge after it hits zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr                <= ID_W'(NUM_REQ - 1);
            cnt                   <= '0;
            bus.conv_targetnumber <= '0;
            bus.conv_fixpointpos  <= '0;
            bus.conv_opcode       <= 1'b0;
            bus.rsp_valid         <= 1'b0;
            bus.rsp_id            <= '0;
            bus.rsp_result        <= '0;
        end else begin
            case (state)
                IDLE: if (any) begin
                    bus.conv_targetnumber <= sel_num;
                    bus.conv_fixpointpos  <= sel_fix;
                    bus.conv_opcode       <= sel_op;
                    bus.rsp_id            <= win;
                    rr_ptr                <= win;
                    cnt                   <= CW'(CONV_LAT);
                end
                WAIT: if (cnt != '0) cnt <= cnt - 1'b1;
                      else begin
                          bus.rsp_result <= bus.conv_result;
                          bus.rsp_valid  <= 1'b1;
                      end
                RESP: if (bus.rsp_ready) bus.rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fixfloat_conv_arbiter.sv
// tb_fixfloat_conv_arbiter: directed checks of grant order, latency, backpressure and reset
// around fixfloat_conv_arbiter with a one-edge fixed->float converter model.
module tb_fixfloat_conv_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   g, t, tp;
    logic seen;
    int          exp_g [5] = '{0, 1, 2, 3, 0};
    logic [31:0] exp_r [4] = '{32'h41040000, 32'hC1040000, 32'hBF000000, 32'h00000000};
    fixfloat_conv_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus ();
    fixfloat_conv_arbiter #(.NUM_REQ(4), .CONV_LAT(1), .ID_W(2)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic logic [31:0] fx2fl(input logic [31:0] n, input logic [4:0] p, input logic op);
        logic [31:0] mag;
        logic [31:0] man;
        logic [7:0]  e;
        int          m;
        if (op) return n;
        if (n == 32'h0) return 32'h0;
        mag = n[31] ? -n : n;
        m = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) m = i;
        e = 8'(127 + m - int'(p));
        man = (m >= 23) ? mag >> (m - 23) : mag << (23 - m);
        return {n[31], e, man[22:0]};
    endfunction
    // Converter: result stable one clock edge after it samples its inputs.
    always @(posedge clk) bus.conv_result <= fx2fl(bus.conv_targetnumber, bus.conv_fixpointpos, bus.conv_opcode);
    function automatic int oh2i(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(negedge clk);
        #1;
    endtask
    task automatic next_grant(output int gi, output int ti);
        gi = -1;
        ti = 0;
        for (int c = 0; c < 30; c++) begin
            if (|bus.req_ready) begin
                gi = oh2i(bus.req_ready);
                ti = cyc;
                chk("grant_onehot", 32'($onehot(bus.req_ready)), 32'd1);
                break;
            end
            tick();
        end
    endtask
    task automatic wait_rsp();
        for (int c = 0; c < 30 && !bus.rsp_valid; c++) tick();
    endtask
    task automatic wait_idle();
        for (int c = 0; c < 30 && bus.busy; c++) tick();
        chk("idle", 32'(bus.busy), 32'd0);
    endtask
    task automatic set_req(input int i, input logic [31:0] n, input logic [4:0] p);
        bus.req_number[32*i +: 32] = n;
        bus.req_fixpos[5*i +: 5]   = p;
        bus.req_opcode[i]          = 1'b0;
    endtask
    initial begin
        bus.req_valid  = '0;
        bus.req_number = '0;
        bus.req_fixpos = '0;
        bus.req_opcode = '0;
        bus.rsp_ready  = 1'b1;
        #2;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("rst_rsp_result", bus.rsp_result, 32'd0);
        chk("rst_conv_num", bus.conv_targetnumber, 32'd0);
        tick();
        rst = 1'b1;
        // single request
        set_req(0, 32'h00000420, 5'd7);
        bus.req_valid = 4'b0001;
        #1;
        chk("t1_ready", 32'(bus.req_ready), 32'd1);
        chk("t1_busy_idle", 32'(bus.busy), 32'd0);
        tick();
        bus.req_valid = '0;
        chk("t1_ready_wait", 32'(bus.req_ready), 32'd0);
        chk("t1_conv_num", bus.conv_targetnumber, 32'h420);
        chk("t1_conv_fix", 32'(bus.conv_fixpointpos), 32'd7);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        chk("t1_no_rsp0", 32'(bus.rsp_valid), 32'd0);
        tick();
        chk("t1_no_rsp1", 32'(bus.rsp_valid), 32'd0);
        tick();
        chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("t1_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("t1_rsp_result", bus.rsp_result, 32'h41040000);
        tick();
        chk("t1_rsp_done", 32'(bus.rsp_valid), 32'd0);
        chk("t1_back_idle", 32'(bus.busy), 32'd0);
        // all four valid after a fresh reset
        rst = 1'b0;
        tick();
        rst = 1'b1;
        set_req(1, 32'hFFFFFEF8, 5'd5);
        set_req(2, 32'hFFFFFFFF, 5'd1);
        set_req(3, 32'h00000000, 5'd1);
        bus.req_valid = 4'b1111;
        #1;
        tp = 0;
        for (int k = 0; k < 5; k++) begin
            next_grant(g, t);
            chk("t2_grant", g, exp_g[k]);
            if (k > 0) chk("t2_spacing", t - tp, 32'd4);
            tp = t;
            if (k < 4) begin
                tick();
                wait_rsp();
                chk("t2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
                chk("t2_rsp_id", 32'(bus.rsp_id), exp_g[k]);
                chk("t2_rsp_result", bus.rsp_result, exp_r[exp_g[k]]);
                tick();
            end
        end
        tick();
        bus.req_valid = '0;
        wait_idle();
        // backpressure on the response channel
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0010;
        #1;
        next_grant(g, t);
        chk("t3_grant", g, 32'd1);
        tick();
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("t3_hold_id", 32'(bus.rsp_id), 32'd1);
            chk("t3_hold_result", bus.rsp_result, 32'hC1040000);
            chk("t3_no_ready", 32'(bus.req_ready), 32'd0);
            if (i < 4) tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        chk("t3_released", 32'(bus.rsp_valid), 32'd0);
        chk("t3_regrant", 32'(bus.req_ready), 32'b0010);
        tick();
        bus.req_valid = '0;
        wait_idle();
        // fairness between 1 and 3, then 0 jumps in after 3
        bus.req_valid = 4'b1010;
        #1;
        next_grant(g, t);
        chk("t4_grant_a", g, 32'd3);
        tick();
        next_grant(g, t);
        chk("t4_grant_b", g, 32'd1);
        tick();
        next_grant(g, t);
        chk("t4_grant_c", g, 32'd3);
        tick();
        bus.req_valid = 4'b1011;
        next_grant(g, t);
        chk("t4_grant_0", g, 32'd0);
        tick();
        bus.req_valid = '0;
        wait_idle();
        // async reset while waiting on the converter
        set_req(2, 32'h00000008, 5'd5);
        bus.req_valid = 4'b0100;
        #1;
        next_grant(g, t);
        chk("t5_grant", g, 32'd2);
        tick();
        bus.req_valid = '0;
        chk("t5_busy_wait", 32'(bus.busy), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("t5_rst_busy", 32'(bus.busy), 32'd0);
        chk("t5_rst_num", bus.conv_targetnumber, 32'd0);
        chk("t5_rst_fix", 32'(bus.conv_fixpointpos), 32'd0);
        tick();
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | bus.rsp_valid;
        end
        chk("t5_dropped", 32'(seen), 32'd0);
        bus.req_valid = 4'b0100;
        #1;
        next_grant(g, t);
        chk("t5_regrant", g, 32'd2);
        tick();
        bus.req_valid = '0;
        wait_rsp();
        chk("t5_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("t5_rsp_id", 32'(bus.rsp_id), 32'd2);
        chk("t5_rsp_result", bus.rsp_result, 32'h3E800000);
        tick();
        wait_idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
